// File: rtl/bcd_serial_adder_ctrl_if.sv
// Handshake and operand/result bundle for bcd_serial_adder_ctrl.
//   start   : request, master -> slave
//   a, b    : packed BCD operands, master -> slave
//   busy    : digits being added, slave -> master
//   done    : one-cycle result-valid pulse, slave -> master
//   sum     : packed BCD result, slave -> master
//   cout    : decimal carry out of the top digit, slave -> master
//   invalid : some operand digit was above 9, slave -> master
interface bcd_serial_adder_ctrl_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   sum;
    logic                  cout;
    logic                  invalid;

    modport master (
        output start, a, b,
        input  busy, done, sum, cout, invalid
    );

    modport slave (
        input  start, a, b,
        output busy, done, sum, cout, invalid
    );
endinterface

// File: rtl/bcd_serial_adder_ctrl.sv
// Sequenced multi-digit BCD adder: one shared digit-add stage walks the
// operands from the least significant digit upward, one digit per clock.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : slave side of bcd_serial_adder_ctrl_if (start/a/b in;
//         busy/done/sum/cout/invalid out)
// Latency: start sampled at E0, busy in cycles 1..DIGITS, done in DIGITS+1.
module bcd_serial_adder_ctrl #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    bcd_serial_adder_ctrl_if.slave  bus
);
    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t          state, state_next;
    logic [W-1:0]    op_a, op_b, sum_r;
    logic [IW-1:0]   idx;
    logic            carry, cout_r, invalid_r;

    logic [3:0]      dig_a, dig_b, dig_sum;
    logic [4:0]      t;
    logic            carry_next;
    logic            start_invalid;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (bus.start)        state_next = ADD;
            ADD:  if (idx == LAST_IDX)  state_next = DONE;
            DONE:                       state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    // Digit select from the latched operands
    always_comb begin
        dig_a = '0;
        dig_b = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                dig_a = op_a[4*i +: 4];
                dig_b = op_b[4*i +: 4];
            end
        end
    end

    // Shared BCD digit stage; digits 10..15 take the same rule unsaturated
    always_comb begin
        t = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0, carry};
        if (t > 5'd9) begin
            dig_sum    = t[3:0] + 4'd6;
            carry_next = 1'b1;
        end else begin
            dig_sum    = t[3:0];
            carry_next = 1'b0;
        end
    end

    // Any non-decimal digit on the incoming operands
    always_comb begin
        start_invalid = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bus.a[4*i +: 4] > 4'd9 || bus.b[4*i +: 4] > 4'd9)
                start_invalid = 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a      <= '0;
            op_b      <= '0;
            sum_r     <= '0;
            idx       <= '0;
            carry     <= 1'b0;
            cout_r    <= 1'b0;
            invalid_r <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_a      <= bus.a;
                        op_b      <= bus.b;
                        sum_r     <= '0;
                        idx       <= '0;
                        carry     <= 1'b0;
                        invalid_r <= start_invalid;
                    end
                end
                ADD: begin
                    for (int unsigned i = 0; i < DIGITS; i++) begin
                        if (idx == IW'(i)) sum_r[4*i +: 4] <= dig_sum;
                    end
                    carry <= carry_next;
                    if (idx == LAST_IDX) cout_r <= carry_next;
                    else                 idx    <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state == ADD);
    assign bus.done    = (state == DONE);
    assign bus.sum     = sum_r;
    assign bus.cout    = cout_r;
    assign bus.invalid = invalid_r;
endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Directed bench for bcd_serial_adder_ctrl with DIGITS=4.
// Inputs change and outputs are sampled on the falling edge.
module tb_bcd_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    bcd_serial_adder_ctrl_if #(.DIGITS(4)) bus ();

    bcd_serial_adder_ctrl #(.DIGITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at the falling edge of cycle 0; returns at the falling edge of cycle 6.
    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic [15:0] es, input logic ec, input logic ei);
        bus.a = av; bus.b = bv; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, " busy c1"}, 32'(bus.busy), 32'd1);
        check({tag, " invalid c1"}, 32'(bus.invalid), 32'(ei));
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            check($sformatf("%s busy/done c%0d", tag, c), {30'd0, bus.busy, bus.done}, 32'b10);
        end
        @(negedge clk);
        check({tag, " busy/done c5"}, {30'd0, bus.busy, bus.done}, 32'b01);
        check({tag, " sum"}, 32'(bus.sum), 32'(es));
        check({tag, " cout"}, 32'(bus.cout), 32'(ec));
        check({tag, " invalid"}, 32'(bus.invalid), 32'(ei));
        @(negedge clk);
        check({tag, " done c6"}, 32'(bus.done), 32'd0);
        check({tag, " sum hold"}, 32'(bus.sum), 32'(es));
    endtask

    initial begin
        int dones;
        rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset sum", 32'(bus.sum), 32'h0000);
        check("reset cout", 32'(bus.cout), 32'd0);
        check("reset invalid", 32'(bus.invalid), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("basic", 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0);
        run_op("ripple", 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0);
        run_op("ripple2", 16'h0505, 16'h0495, 16'h1000, 1'b0, 1'b0);

        // Start re-asserted in cycle 2 with other operands must be ignored
        bus.a = 16'h2222; bus.b = 16'h3333; bus.start = 1'b1;
        dones = 0;
        @(negedge clk);                                     // cycle 1
        bus.start = 1'b0;
        dones += int'(bus.done);
        @(negedge clk);                                     // cycle 2
        bus.a = 16'h9999; bus.b = 16'h9999; bus.start = 1'b1;
        dones += int'(bus.done);
        for (int c = 3; c <= 4; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            dones += int'(bus.done);
        end
        @(negedge clk);                                     // cycle 5
        check("busy-start done c5", 32'(bus.done), 32'd1);
        check("busy-start sum", 32'(bus.sum), 32'h5555);
        dones += int'(bus.done);
        check("busy-start done count", 32'(dones), 32'd1);
        @(negedge clk);                                     // cycle 6: back-to-back start
        run_op("b2b", 16'h0100, 16'h0200, 16'h0300, 1'b0, 1'b0);

        run_op("invalid", 16'h000A, 16'h0005, 16'h0015, 1'b0, 1'b1);

        // Reset taken at E2 aborts the operation
        bus.a = 16'h1234; bus.b = 16'h1111; bus.start = 1'b1;
        @(negedge clk);                                     // cycle 1
        bus.start = 1'b0;
        @(negedge clk);                                     // cycle 2
        rst = 1'b1;
        @(negedge clk);                                     // cycle 3
        rst = 1'b0;
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort sum", 32'(bus.sum), 32'h0000);
        check("abort flags", {29'd0, bus.done, bus.cout, bus.invalid}, 32'd0);
        dones = 0;
        repeat (4) begin
            @(negedge clk);
            dones += int'(bus.done);
        end
        check("abort no done", 32'(dones), 32'd0);
        run_op("after-abort", 16'h4321, 16'h1111, 16'h5432, 1'b0, 1'b0);

        // Reset and start together: reset wins
        bus.a = 16'h0001; bus.b = 16'h0001; bus.start = 1'b1; rst = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; rst = 1'b0;
        check("rst+start busy", 32'(bus.busy), 32'd0);
        check("rst+start sum", 32'(bus.sum), 32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bcd_serial_adder_ctrl.md
# bcd_serial_adder_ctrl

Sequenced multi-digit BCD adder. It shares one 4-bit BCD digit-add stage across all digits of two packed-BCD operands, processing one digit per clock from the least significant digit upward. The block runs a start/busy/done handshake, so a host FSM or testbench can issue N-digit decimal additions without N copies of the combinational digit adder. It sits one level above the combinational BCD digit adder in the lab datapath.

## Interface
Parameters:
- DIGITS, 4, number of BCD digits per operand (≥1); operand width is 4*DIGITS.

Ports:
- clk  in  1  single clock, all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- a  in  4*DIGITS  packed BCD operand A; digit i occupies bits [4i+3:4i].
- b  in  4*DIGITS  packed BCD operand B, same packing as A.
- busy  out  1  high while digits are being added.
- done  out  1  one-cycle pulse when sum/cout are valid.
- sum  out  4*DIGITS  packed BCD result.
- cout  out  1  decimal carry out of the most significant digit.
- invalid  out  1  set if any input digit of A or B was >9 at the start sample.

## Operation
- States: IDLE, ADD, DONE.
- IDLE: if start=1, latch a and b into operand registers, clear the carry register, set the digit index to 0, clear sum, and compute invalid from the latched digits. Next state is ADD. If start=0, stay in IDLE.
- ADD: each cycle, the shared digit stage computes t = A[idx] + B[idx] + carry as a 5-bit value.
  - If t > 9: digit = (t + 6) mod 16 and carry = 1.
  - Otherwise: digit = t[3:0] and carry = 0.
  - Write the digit to sum[4idx+3:4idx] and increment idx.
  - When idx = DIGITS-1, the next state is DONE and cout takes the final carry.
- DONE: done=1 for exactly one cycle. The next state is IDLE.
- start is ignored in ADD and DONE. It is not queued.
- Changes on a and b after the start sample have no effect.
- Invalid digits (10–15) go through the same arithmetic rule with no saturation. invalid flags the result as undefined in decimal terms.
- sum, cout and invalid hold their values from DONE until the next accepted start.
- Reset: rst=1 at any edge forces IDLE and clears idx, carry, sum, cout, invalid, busy and done. This aborts any operation in progress with no done pulse.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, invalid=0.
- start is high in cycle 0 and sampled at edge E0. busy=1 in cycles 1..DIGITS. done=1 in cycle DIGITS+1 only. The block is back in IDLE in cycle DIGITS+2.
- The earliest next start is in cycle DIGITS+2, giving a throughput of one operation per DIGITS+2 cycles.
- sum and cout are guaranteed valid when done=1 and afterwards. Partial digits are visible while busy=1 but are not valid.
- invalid becomes valid from cycle 1.
- rst and start high at the same edge: reset wins.
- DIGITS=1: ADD lasts one cycle and done is in cycle 2.
- idx width is clog2(DIGITS), minimum 1. idx never wraps, because the state leaves ADD at DIGITS-1.

## Test plan
All scenarios use DIGITS=4.
- Reset: assert rst for 2 cycles -> busy=0, done=0, sum=0x0000, cout=0, invalid=0.
- Basic add: a=0x1234, b=0x5678, start for 1 cycle -> busy high for 4 cycles; done in cycle 5 with sum=0x6912, cout=0, invalid=0.
- Carry ripple: a=0x9999, b=0x0001 -> sum=0x0000, cout=1.
  - Follow with a=0x0505, b=0x0495 -> sum=0x1000, cout=0.
- Start while busy: start pulses again in cycle 2 with new operands -> ignored; exactly one done, in cycle 5, with the original result.
  - Next start in cycle 6 is accepted and gives done in cycle 11.
- Invalid digit: a=0x000A, b=0x0005 -> invalid=1 from cycle 1; sum=0x0015, cout=0 (t=15 → 5, carry 1).
- Reset mid-op: rst at the E2 edge -> IDLE next cycle, all outputs 0, no done.
  - A new start of 0x4321+0x1111 then gives sum=0x5432.
